mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the data-memory port: the load/store engine between the datapath and the 256x16
//  data memory. Accepts one request per valid/ready handshake, drives MemRead/MemWrite/address/write data,
//  captures the memory's registered read data and returns it on a response handshake with backpressure.
//  Supports single store, atomic swap (read-old + write-new in one memory cycle) and burst loads of 1..8 words.
// PARAMETERS
//  ADDR_W     8   memory address width (byte address, words on even addresses)
//  DATA_W     16  memory word width
//  ADDR_STEP  2   address increment between burst beats
//  LEN_W      3   burst length field width; beats = req_len+1 (1..8)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-low
//  req_valid    in   1       request present
//  req_ready    out  1       engine idle, request accepted when valid&&ready
//  req_op       in   2       00 load, 01 store, 10 swap, 11 reserved
//  req_addr     in   ADDR_W  start address
//  req_wdata    in   DATA_W  store/swap data
//  req_len      in   LEN_W   load beats-1; ignored for store/swap
//  rsp_valid    out  1       response beat present
//  rsp_ready    in   1       consumer takes beat when valid&&ready
//  rsp_rdata    out  DATA_W  load/swap data; 0 for store and error
//  rsp_last     out  1       final beat of the request
//  rsp_err      out  1       reserved op; no memory access made
//  MemRead      out  1       to memory read enable
//  MemWrite     out  1       to memory write enable
//  Memaddr_out  out  ADDR_W  to memory address
//  mem_wdata    out  DATA_W  to memory write data
//  mem_rdata    in   DATA_W  from memory registered read data (valid the cycle after MemRead)
// BEHAVIOUR
//  - Reset low: state IDLE, beat counter 0, MemRead=MemWrite=0, Memaddr_out=0, mem_wdata=0, rsp_*=0;
//    req_ready=1 but nothing is accepted while reset is low. Reset mid-operation abandons the request
//    immediately: memory strobes drop asynchronously, no response is produced.
//  - All outputs registered except req_ready = (state==IDLE).
//  - States: IDLE, RD_ISSUE, RD_CAP, WR, SWAP, RSP.
//    IDLE: on handshake latch op/addr/wdata/len; load->RD_ISSUE, store->WR, swap->SWAP,
//      reserved->RSP with rsp_err=1, rsp_last=1, rsp_rdata=0.
//    RD_ISSUE: MemRead=1, Memaddr_out=cur_addr for exactly 1 cycle -> RD_CAP.
//    SWAP: MemRead=1 and MemWrite=1 same cycle, mem_wdata=wdata -> RD_CAP (old value returned).
//    WR: MemWrite=1 for exactly 1 cycle -> RSP with rsp_rdata=0, rsp_last=1.
//    RD_CAP: strobes low; register mem_rdata into rsp_rdata; rsp_last=(beats_left==0) -> RSP.
//    RSP: rsp_valid=1, outputs stable until rsp_ready. On handshake: beats_left!=0 ->
//      cur_addr+=ADDR_STEP, beats_left-=1, RD_ISSUE; else IDLE.
//  - Load latency: accept at edge 0, MemRead high cycle 1, rsp_valid high from cycle 3. Next burst beat
//    issues the cycle after the rsp handshake; no read is issued while a beat is unacknowledged
//    (memory data_out would be overwritten).
//  - Address arithmetic modulo 2^ADDR_W: 8'hFE+2 -> 8'h00, burst continues across wrap.
//  - MemRead/MemWrite never asserted in IDLE, RD_CAP or RSP. Back-to-back requests: req_ready rises the
//    cycle after the final rsp handshake; minimum 3 cycles per store, 4 per single load.
//  - req_* sampled only at accept; later changes ignored.
// STRUCTURE
//  - Shared package mem_pkg: ADDR_W/DATA_W constants, op encodings (OP_LOAD/OP_STORE/OP_SWAP/OP_RSVD),
//    state encoding for this FSM.
//  - One sub-module: burst_addr_gen (load start addr+len, step on advance, outputs cur_addr and last).
//  - Top holds FSM, request latch and response register.
// TESTING (memory model preloaded: 00=2BCD 04=1234 06=DEAD 08=BEEF, rest 0)
//  1 load 04, len0, rsp_ready=1 -> MemRead 1 cycle addr 04; rsp_valid at cycle 3, rdata 1234, last=1.
//  2 load 04, len2, rsp_ready low 5 cycles on beat 1 -> beats 1234,DEAD,BEEF, last on 3rd only; no MemRead
//    while beat held; rdata stable.
//  3 store 10 data A5A5 then load 10 -> MemWrite 1 cycle, ack rdata 0 last=1; load returns A5A5.
//  4 swap 00 data 5555 -> MemRead&MemWrite same cycle; rsp 2BCD; subsequent load 00 returns 5555.
//  5 load FE len1 with FE=0011 -> beats 0011 then 2BCD (addr wraps to 00); reserved op -> rsp_err=1,
//    no strobes.
//  6 reset low during RSP of a burst -> strobes/rsp_valid 0 immediately; after release IDLE, req_ready=1,
//    fresh load works.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory load/store engine: widths, op codes and FSM states.
package mem_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int ADDR_STEP = 2;
  localparam int LEN_W     = 3;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_SWAP  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAP   = 3'd2,
    ST_WR       = 3'd3,
    ST_SWAP     = 3'd4,
    ST_RSP      = 3'd5
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_burst_addr_gen.sv
// Burst address generator: holds the current beat address and the number of beats remaining.
module burst_addr_gen
  import mem_pkg::*;
#(
  parameter int AW   = ADDR_W,
  parameter int LW   = LEN_W,
  parameter int STEP = ADDR_STEP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [AW-1:0] start_addr_i,
  input  logic [LW-1:0] len_i,
  input  logic          advance_i,
  output logic [AW-1:0] cur_addr_o,
  output logic [AW-1:0] next_addr_o,
  output logic          last_o
);

  logic [AW-1:0] addr_q;
  logic [LW-1:0] left_q;

  // Address and remaining-beat registers; the add wraps modulo 2^AW
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      left_q <= '0;
    end else if (load_i) begin
      addr_q <= start_addr_i;
      left_q <= len_i;
    end else if (advance_i) begin
      addr_q <= next_addr_o;
      left_q <= left_q - LW'(1);
    end else begin
      addr_q <= addr_q;
      left_q <= left_q;
    end
  end

  assign next_addr_o = addr_q + AW'(STEP);
  assign cur_addr_o  = addr_q;
  assign last_o      = (left_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store engine between the datapath and the data memory: request latch, FSM, registered
// memory strobes and a backpressured response register.
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Memaddr_out,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_last_q, rsp_last_d;
  logic                rsp_err_q, rsp_err_d;

  logic                gen_load, gen_adv, gen_last;
  logic [LEN_W-1:0]    gen_len;
  logic [ADDR_W-1:0]   gen_cur, gen_next;

  // Store/swap/reserved are single-beat, so the generator sees a zero length for them
  assign gen_len = (req_op == OP_LOAD) ? req_len : '0;

  burst_addr_gen #(.AW(ADDR_W), .LW(LEN_W), .STEP(ADDR_STEP)) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load_i       (gen_load),
    .start_addr_i (req_addr),
    .len_i        (gen_len),
    .advance_i    (gen_adv),
    .cur_addr_o   (gen_cur),
    .next_addr_o  (gen_next),
    .last_o       (gen_last)
  );

  // Next-state and next-output logic; strobes are computed one state ahead so they are registered
  always_comb begin
    state_d     = state_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    gen_load    = 1'b0;
    gen_adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          gen_load = 1'b1;
          case (op_e'(req_op))
            OP_LOAD: begin
              state_d    = ST_RD_ISSUE;
              mem_read_d = 1'b1;
              addr_d     = req_addr;
            end
            OP_STORE: begin
              state_d     = ST_WR;
              mem_write_d = 1'b1;
              addr_d      = req_addr;
              wdata_d     = req_wdata;
            end
            OP_SWAP: begin
              state_d     = ST_SWAP;
              mem_read_d  = 1'b1;
              mem_write_d = 1'b1;
              addr_d      = req_addr;
              wdata_d     = req_wdata;
            end
            default: begin
              state_d     = ST_RSP;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = '0;
              rsp_last_d  = 1'b1;
              rsp_err_d   = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ISSUE, ST_SWAP: begin
        state_d = ST_RD_CAP;
      end
      ST_WR: begin
        state_d     = ST_RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_last_d  = 1'b1;
        rsp_err_d   = 1'b0;
      end
      ST_RD_CAP: begin
        state_d     = ST_RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_rdata;
        rsp_last_d  = gen_last;
        rsp_err_d   = 1'b0;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!gen_last) begin
            gen_adv    = 1'b1;
            addr_d     = gen_next;
            mem_read_d = 1'b1;
            state_d    = ST_RD_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops strobes and any pending response at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign MemRead     = mem_read_q;
  assign MemWrite    = mem_write_q;
  assign Memaddr_out = addr_q;
  assign mem_wdata   = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_last    = rsp_last_q;
  assign rsp_err     = rsp_err_q;

  logic unused_s;
  assign unused_s = ^gen_cur;

endmodule
